add3_pipe: RTL and testbench

ADD3_PIPE -- requirements
Module: add3_pipe

---
 rtl/add3_pipe.sv | 137 +++++++++++++
 tb/tb_add3_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add3_pipe.sv
// add3_pipe: pipelined three-operand adder with a post-add left rotate.
//   Result o = ROTL((a+b+c) mod 2^WIDTH, rot); co = bits [WIDTH+1:WIDTH] of a+b+c.
//   Latency is STAGES enabled cycles (STAGES = 1 or 2).
// Ports:
//   CLK        clock; all state updates on its rising edge
//   rst        synchronous active-high reset; clears valids, o and co
//   en         pipeline advance; 0 freezes every stage
//   in_valid   a, b, c, rot carry an operation this cycle
//   a, b, c    addends (WIDTH bits)
//   rot        left-rotate amount (ROTW bits)
//   out_valid  o/co hold a completed result this cycle
//   o          rotated wrapped sum (registered)
//   co         2-bit overflow of the unrotated sum (registered)
module add3_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ROTW   = 5
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [ROTW-1:0]  rot,
  output logic             out_valid,
  output logic [WIDTH-1:0] o,
  output logic [1:0]       co
);

  localparam int unsigned SUMW = WIDTH + 2;

  // Parameter legality checks at elaboration time.
  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("add3_pipe: WIDTH must be even and within 8..64");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("add3_pipe: STAGES must be 1 or 2");
  end
  if ((1 << ROTW) != WIDTH) begin : g_bad_rotw
    $error("add3_pipe: 2**ROTW must equal WIDTH");
  end

  // Left rotate: the upper half of a doubled word shifted left is the rotation.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input logic [ROTW-1:0]  r);
    logic [2*WIDTH-1:0] t;
    t = {x, x} << r;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  if (STAGES == 1) begin : g_one
    logic [SUMW-1:0] sum_c;

    // Full-precision sum straight from the inputs.
    always_comb begin
      sum_c = SUMW'(a) + SUMW'(b) + SUMW'(c);
    end

    // Single result stage; o/co only move when a valid op completes.
    always_ff @(posedge CLK) begin
      if (rst) begin
        out_valid <= 1'b0;
        o         <= '0;
        co        <= 2'b00;
      end else if (en) begin
        out_valid <= in_valid;
        if (in_valid) begin
          o  <= rotl(sum_c[WIDTH-1:0], rot);
          co <= sum_c[SUMW-1:WIDTH];
        end
      end
    end
  end else begin : g_two
    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned HSUMW = HALF + 2;

    logic             s1_valid;
    logic [HALF-1:0]  s1_lo;
    logic [1:0]       s1_cy;
    logic [HALF-1:0]  s1_ah;
    logic [HALF-1:0]  s1_bh;
    logic [HALF-1:0]  s1_ch;
    logic [ROTW-1:0]  s1_rot;

    logic [HSUMW-1:0] lo_c;
    logic [HSUMW-1:0] hi_c;
    logic [SUMW-1:0]  sum_c;

    // Low-half sum feeds stage 1; high half plus stage-1 carry feeds stage 2.
    always_comb begin
      lo_c  = HSUMW'(a[HALF-1:0]) + HSUMW'(b[HALF-1:0]) + HSUMW'(c[HALF-1:0]);
      hi_c  = HSUMW'(s1_ah) + HSUMW'(s1_bh) + HSUMW'(s1_ch) + HSUMW'(s1_cy);
      sum_c = {hi_c, s1_lo};
    end

    // Stage 1: low-half sum with its carry, upper operands and rotate amount.
    always_ff @(posedge CLK) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_lo    <= '0;
        s1_cy    <= 2'b00;
        s1_ah    <= '0;
        s1_bh    <= '0;
        s1_ch    <= '0;
        s1_rot   <= '0;
      end else if (en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_lo  <= lo_c[HALF-1:0];
          s1_cy  <= lo_c[HSUMW-1:HALF];
          s1_ah  <= a[WIDTH-1:HALF];
          s1_bh  <= b[WIDTH-1:HALF];
          s1_ch  <= c[WIDTH-1:HALF];
          s1_rot <= rot;
        end
      end
    end

    // Stage 2: finish the upper half, split off the overflow, rotate.
    always_ff @(posedge CLK) begin
      if (rst) begin
        out_valid <= 1'b0;
        o         <= '0;
        co        <= 2'b00;
      end else if (en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          o  <= rotl(sum_c[WIDTH-1:0], s1_rot);
          co <= sum_c[SUMW-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_add3_pipe.sv
// Bench for add3_pipe: one STAGES=2 and one STAGES=1 instance (WIDTH=32) share
// the same stimulus. Directed vectors and hand sequences use bench constants;
// every cycle both instances are also compared to an operation-history model.
module tb_add3_pipe;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [4:0]  rot;

  logic        ov1, ov2;
  logic [31:0] o1, o2;
  logic [1:0]  co1, co2;

  int n_checks = 0;
  int n_errors = 0;

  add3_pipe #(.WIDTH(32), .STAGES(2), .ROTW(5)) u_dut2 (
    .CLK(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .rot(rot),
    .out_valid(ov2), .o(o2), .co(co2)
  );

  add3_pipe #(.WIDTH(32), .STAGES(1), .ROTW(5)) u_dut1 (
    .CLK(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .rot(rot),
    .out_valid(ov1), .o(o1), .co(co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] o;
    logic [1:0]  co;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  rot;
    logic [31:0] exp_o;
    logic [1:0]  exp_co;
  } vec_t;

  // History of enabled edges since reset; index [0]=STAGES 1, [1]=STAGES 2.
  ent_t        hist[$];
  logic        exp_v[2];
  logic [31:0] exp_o[2];
  logic [1:0]  exp_co[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for a single operation.
  function automatic void ref_calc(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] z, input logic [4:0] r,
                                   output logic [31:0] ro, output logic [1:0] rc);
    logic [33:0] s;
    logic [63:0] t;
    s  = 34'(x) + 34'(y) + 34'(z);
    t  = 64'(s[31:0]) << r;
    ro = t[31:0] | t[63:32];
    rc = s[33:32];
  endfunction

  // Result visible after an enabled edge is the op taken depth-1 enabled edges earlier.
  task automatic model_step();
    ent_t e;
    int   depth;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        exp_v[k] = 1'b0; exp_o[k] = '0; exp_co[k] = 2'b00;
      end
    end else if (en) begin
      e.v = in_valid;
      ref_calc(a, b, c, rot, e.o, e.co);
      hist.push_back(e);
      if (hist.size() > 2) void'(hist.pop_front());
      for (int k = 0; k < 2; k++) begin
        depth = k + 1;
        if (hist.size() >= depth) begin
          e = hist[hist.size() - depth];
          exp_v[k] = e.v;
          if (e.v) begin
            exp_o[k]  = e.o;
            exp_co[k] = e.co;
          end
        end else begin
          exp_v[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_check();
    chk("s1_model_valid", 64'(ov1), 64'(exp_v[0]));
    chk("s1_model_o",     64'(o1),  64'(exp_o[0]));
    chk("s1_model_co",    64'(co1), 64'(exp_co[0]));
    chk("s2_model_valid", 64'(ov2), 64'(exp_v[1]));
    chk("s2_model_o",     64'(o2),  64'(exp_o[1]));
    chk("s2_model_co",    64'(co2), 64'(exp_co[1]));
  endtask

  // Drive at negedge, clock one edge, update model, compare at next negedge.
  task automatic cycle(input logic r, input logic e, input logic v,
                       input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] cc, input logic [4:0] rr);
    rst = r; en = e; in_valid = v; a = aa; b = bb; c = cc; rot = rr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  vec_t        vecs[$];
  logic [31:0] xa[4], xb[4], xc[4], xo[4];
  logic [4:0]  xr[4];
  logic [1:0]  xco[4];

  initial begin
    vecs.push_back('{32'h00000001, 32'h00000002, 32'h00000003, 5'd0,  32'h00000006, 2'd0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFD, 2'd2});
    vecs.push_back('{32'h0000FFFF, 32'h00000001, 32'h00000000, 5'd0,  32'h00010000, 2'd0});
    vecs.push_back('{32'h80000000, 32'h00000001, 32'h00000000, 5'd4,  32'h00000018, 2'd0});
    vecs.push_back('{32'h00000002, 32'h00000000, 32'h00000000, 5'd31, 32'h00000001, 2'd0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd1,  32'h00000000, 2'd1});
    vecs.push_back('{32'h40000000, 32'h40000000, 32'h40000000, 5'd0,  32'hC0000000, 2'd0});
    vecs.push_back('{32'h0000FFFF, 32'h00000000, 32'h00000000, 5'd16, 32'hFFFF0000, 2'd0});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'h80000000, 5'd1,  32'h00000001, 2'd1});

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; rot = '0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 1'b1, 32'h5, 32'h5, 32'h5, 5'd0);
    chk("reset_ov2", 64'(ov2), 64'd0);
    chk("reset_o2",  64'(o2),  64'd0);
    chk("reset_co2", 64'(co2), 64'd0);
    chk("reset_ov1", 64'(ov1), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, 5'd0);

    // Table: isolated ops; STAGES=1 result after 1 edge, STAGES=2 after 2.
    foreach (vecs[i]) begin
      cycle(1'b0, 1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rot);
      chk("vec_ov1", 64'(ov1), 64'd1);
      chk("vec_o1",  64'(o1),  64'(vecs[i].exp_o));
      chk("vec_co1", 64'(co1), 64'(vecs[i].exp_co));
      cycle(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1, 32'h2, 5'd3);
      chk("vec_ov2", 64'(ov2), 64'd1);
      chk("vec_o2",  64'(o2),  64'(vecs[i].exp_o));
      chk("vec_co2", 64'(co2), 64'(vecs[i].exp_co));
      chk("vec_hold_ov1", 64'(ov1), 64'd0);
      chk("vec_hold_o1",  64'(o1),  64'(vecs[i].exp_o));
    end
    cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, 5'd0);

    // Stall and stream: 4 ops, en low for 3 cycles after the 2nd edge.
    for (int i = 0; i < 4; i++) begin
      xa[i] = $urandom; xb[i] = $urandom; xc[i] = $urandom; xr[i] = 5'($urandom);
      ref_calc(xa[i], xb[i], xc[i], xr[i], xo[i], xco[i]);
    end
    cycle(1'b0, 1'b1, 1'b1, xa[0], xb[0], xc[0], xr[0]);
    cycle(1'b0, 1'b1, 1'b1, xa[1], xb[1], xc[1], xr[1]);
    chk("stall_pre_ov2", 64'(ov2), 64'd1);
    chk("stall_pre_o2",  64'(o2),  64'(xo[0]));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 5'd7);
      chk("stall_ov2",  64'(ov2), 64'd1);
      chk("stall_o2",   64'(o2),  64'(xo[0]));
      chk("stall_co2",  64'(co2), 64'(xco[0]));
      chk("stall_o1",   64'(o1),  64'(xo[1]));
    end
    cycle(1'b0, 1'b1, 1'b1, xa[2], xb[2], xc[2], xr[2]);
    chk("stream1_o2", 64'(o2), 64'(xo[1]));
    cycle(1'b0, 1'b1, 1'b1, xa[3], xb[3], xc[3], xr[3]);
    chk("stream2_o2", 64'(o2), 64'(xo[2]));
    cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, 5'd0);
    chk("stream3_ov2", 64'(ov2), 64'd1);
    chk("stream3_o2",  64'(o2),  64'(xo[3]));
    chk("stream3_co2", 64'(co2), 64'(xco[3]));
    cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, 5'd0);
    chk("stream_end_ov2", 64'(ov2), 64'd0);
    chk("stream_end_o2",  64'(o2),  64'(xo[3]));

    // Reset mid-flight discards everything in the pipe.
    cycle(1'b0, 1'b1, 1'b1, 32'h1, 32'h1, 32'h1, 5'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h7, 32'h7, 32'h7, 5'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h3, 32'h3, 32'h3, 5'd0);
      chk("rstmid_ov2", 64'(ov2), 64'd0);
      chk("rstmid_o2",  64'(o2),  64'd0);
      chk("rstmid_co2", 64'(co2), 64'd0);
      chk("rstmid_ov1", 64'(ov1), 64'd0);
    end

    // First enabled edge after reset accepts normally.
    cycle(1'b0, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 5'd0);
    chk("post_rst_ov1", 64'(ov1), 64'd1);
    chk("post_rst_o1",  64'(o1),  64'h6);
    cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, 5'd0);
    chk("post_rst_ov2", 64'(ov2), 64'd1);
    chk("post_rst_o2",  64'(o2),  64'h6);

    // Reset wins even with en low.
    cycle(1'b0, 1'b1, 1'b1, 32'h5, 32'h5, 32'h5, 5'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h5, 32'h5, 32'h5, 5'd0);
    chk("rst_en0_ov1", 64'(ov1), 64'd0);
    chk("rst_en0_o1",  64'(o1),  64'd0);
    chk("rst_en0_o2",  64'(o2),  64'd0);
    cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, 5'd0);
    chk("rst_en0_ov2", 64'(ov2), 64'd0);

    // Randomized run against the history model.
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] ra, rb, rc;
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0000FFFF : $urandom;
      rc = ($urandom_range(0, 3) == 0) ? 32'h00000000 : $urandom;
      cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            ra, rb, rc, 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
